// File: rtl/ctrlpid_mc.sv
// Time-multiplexed multi-channel incremental PID controller with log2 (shift) gains.
// A free-running prescaler launches a frame that walks every channel, 7 clocks each (2 on clear).
module ctrlpid_mc #(
  parameter int aw = 1,
  parameter int ew = 24,
  parameter int pw = 32,
  parameter int ow = 12,
  parameter int cw = 6,
  parameter int fp = 9,
  parameter int precision = 1,
  parameter int dw = 12,
  parameter logic signed [pw-1:0] antiwindup = pw'(8'hFF) << (precision + ow - 9)
) (
  input  logic                 clk_pid,
  input  logic                 reset,
  output logic [aw-1:0]        a,
  input  logic signed [ew-1:0] error,
  input  logic signed [cw-1:0] KP,
  input  logic signed [cw-1:0] KI,
  input  logic signed [cw-1:0] KD,
  input  logic                 clr,
  output logic                 ce,
  output logic signed [ow-1:0] m_k_out,
  input  logic [aw-1:0]        rd_addr,
  output logic signed [ow-1:0] rd_data
);

  localparam int an = 1 << aw;
  localparam logic [aw-1:0] last_ch = aw'(an - 1);
  localparam logic signed [cw-1:0] fp_c = cw'(fp);
  localparam logic signed [cw-1:0] prec_c = cw'(precision);
  localparam logic signed [cw-1:0] one_c = cw'(1);
  localparam logic signed [pw-1:0] lim_hi = antiwindup;
  localparam logic signed [pw-1:0] lim_lo = -antiwindup;

  typedef enum logic [2:0] {
    S_IDLE, S_LOAD, S_P, S_D, S_I, S_D2, S_CLAMP, S_OUT
  } state_t;

  state_t state;
  logic [dw-1:0] pre;
  logic tick;

  // Working copy of the channel being processed.
  logic signed [pw-1:0] e0, e1w, e2w, uw;
  logic signed [cw-1:0] kp, ki, kd;
  logic signed [cw-1:0] sh_d, sh_d2, sh_i;
  logic signed [ow-1:0] m_new;

  logic signed [pw-1:0] u_mem  [an];
  logic signed [pw-1:0] e1_mem [an];
  logic signed [pw-1:0] e2_mem [an];
  logic signed [ow-1:0] m_mem  [an];

  assign tick  = (pre == {dw{1'b1}});
  assign sh_d  = kd + fp_c;
  assign sh_d2 = kd + fp_c + one_c;
  assign sh_i  = ki - one_c - fp_c;
  assign m_new = uw[precision+ow-1:precision];

  // Signed shift: positive amounts shift left, negative amounts shift right arithmetically.
  function automatic logic signed [pw-1:0] sh(input logic signed [pw-1:0] x,
                                               input logic signed [cw-1:0] s);
    logic [cw-1:0] n;
    n = $unsigned(-s);
    if (s[cw-1]) sh = x >>> n;
    else         sh = x <<< $unsigned(s);
  endfunction

  always_ff @(posedge clk_pid or posedge reset) begin
    if (reset) begin
      state   <= S_IDLE;
      pre     <= '0;
      a       <= '0;
      ce      <= 1'b0;
      m_k_out <= '0;
      rd_data <= '0;
      e0      <= '0;
      e1w     <= '0;
      e2w     <= '0;
      uw      <= '0;
      kp      <= '0;
      ki      <= '0;
      kd      <= '0;
      for (int i = 0; i < an; i++) begin
        u_mem[i]  <= '0;
        e1_mem[i] <= '0;
        e2_mem[i] <= '0;
        m_mem[i]  <= '0;
      end
    end else begin
      pre     <= pre + dw'(1);
      ce      <= 1'b0;
      rd_data <= m_mem[rd_addr];
      case (state)
        S_IDLE: begin
          if (tick) begin
            a     <= '0;
            state <= S_LOAD;
          end
        end
        S_LOAD: begin
          e0  <= {{(pw-ew){error[ew-1]}}, error};
          kp  <= KP + prec_c;
          ki  <= KI + prec_c;
          kd  <= KD + prec_c;
          uw  <= u_mem[a];
          e1w <= e1_mem[a];
          e2w <= e2_mem[a];
          if (clr) begin
            // Zeroing e0 too keeps the history at 0 when OUT shifts it in.
            e0        <= '0;
            uw        <= '0;
            e1w       <= '0;
            e2w       <= '0;
            u_mem[a]  <= '0;
            e1_mem[a] <= '0;
            e2_mem[a] <= '0;
            m_mem[a]  <= '0;
            state     <= S_OUT;
          end else begin
            state <= S_P;
          end
        end
        S_P: begin
          uw    <= uw + sh(e0, kp) - sh(e1w, kp);
          state <= S_D;
        end
        S_D: begin
          uw    <= uw + sh(e0, sh_d) + sh(e2w, sh_d);
          state <= S_I;
        end
        S_I: begin
          uw    <= uw + sh(e0, sh_i) + sh(e1w, sh_i);
          state <= S_D2;
        end
        S_D2: begin
          uw    <= uw - sh(e1w, sh_d2);
          state <= S_CLAMP;
        end
        S_CLAMP: begin
          if (uw > lim_hi)      uw <= lim_hi;
          else if (uw < lim_lo) uw <= lim_lo;
          state <= S_OUT;
        end
        S_OUT: begin
          m_mem[a]  <= m_new;
          m_k_out   <= m_new;
          u_mem[a]  <= uw;
          e1_mem[a] <= e0;
          e2_mem[a] <= e1w;
          ce        <= 1'b1;
          if (a == last_ch) begin
            a     <= '0;
            state <= S_IDLE;
          end else begin
            a     <= a + aw'(1);
            state <= S_LOAD;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ctrlpid_mc.sv
// Bench for ctrlpid_mc (2 channels, 32-clock loop): directed cases, mid-frame reset,
// then random frames against an arithmetic reference model of the PID update.
module tb_ctrlpid_mc;

  localparam int AW  = 1;
  localparam int DW  = 5;
  localparam int LIM = 255 << 4;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  logic [AW-1:0]      a, rd_addr;
  logic signed [23:0] err_in;
  logic signed [5:0]  kp_in, ki_in, kd_in;
  logic               clr_in, ce;
  logic [11:0]        m_k_out, rd_data;

  // External register file, presented combinationally from the DUT's channel address.
  int err_tab[2], kp_tab[2], ki_tab[2], kd_tab[2];
  bit clr_tab[2];

  always_comb begin
    err_in = 24'(err_tab[a]);
    kp_in  = 6'(kp_tab[a]);
    ki_in  = 6'(ki_tab[a]);
    kd_in  = 6'(kd_tab[a]);
    clr_in = clr_tab[a];
  end

  ctrlpid_mc #(.aw(AW), .dw(DW)) dut (
    .clk_pid (clk),
    .reset   (reset),
    .a       (a),
    .error   (err_in),
    .KP      (kp_in),
    .KI      (ki_in),
    .KD      (kd_in),
    .clr     (clr_in),
    .ce      (ce),
    .m_k_out (m_k_out),
    .rd_addr (rd_addr),
    .rd_data (rd_data)
  );

  // ---------------- scoreboard ----------------
  logic [11:0] exp_q[$];
  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // ---------------- reference model ----------------
  int mu[2], me1[2], me2[2];
  logic [11:0] mm[2];

  // x * 2^s, rounded toward minus infinity for negative s, wrapping at 32 bits.
  function automatic int shv(input int x, input int s);
    longint d, q;
    if (s >= 0) return x * (1 << s);
    d = 64'sd1 << (-s);
    q = longint'(x) / d;
    if (q * d > longint'(x)) q = q - 1;
    return int'(q);
  endfunction

  function automatic void model_reset();
    for (int c = 0; c < 2; c++) begin
      mu[c] = 0; me1[c] = 0; me2[c] = 0; mm[c] = '0;
    end
  endfunction

  function automatic logic [11:0] model_ch(input int ch);
    int e0, kp, ki, kd, u;
    if (clr_tab[ch]) begin
      mu[ch] = 0; me1[ch] = 0; me2[ch] = 0; mm[ch] = '0;
      return mm[ch];
    end
    e0 = err_tab[ch];
    kp = kp_tab[ch] + 1;
    ki = ki_tab[ch] + 1;
    kd = kd_tab[ch] + 1;
    u = mu[ch]
        + shv(e0, kp) - shv(me1[ch], kp)
        + shv(e0, kd + 9) + shv(me2[ch], kd + 9)
        + shv(e0, ki - 10) + shv(me1[ch], ki - 10)
        - shv(me1[ch], kd + 10);
    if (u > LIM)       u = LIM;
    else if (u < -LIM) u = -LIM;
    mu[ch]  = u;
    me2[ch] = me1[ch];
    me1[ch] = e0;
    mm[ch]  = 12'(u >>> 1);
    return mm[ch];
  endfunction

  // ---------------- driver tasks ----------------
  task automatic set_ch(input int ch, input int e, input int kp, input int ki, input int kd, input bit c);
    err_tab[ch] = e; kp_tab[ch] = kp; ki_tab[ch] = ki; kd_tab[ch] = kd; clr_tab[ch] = c;
  endtask

  task automatic wait_ce(output int n);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (ce !== 1'b1 && n < 200);
  endtask

  task automatic run_frame(input string tag, input bit after_reset,
                           output logic [11:0] obs0, output logic [11:0] obs1);
    logic [11:0] old1;
    int n;
    old1 = mm[1];
    exp_q.push_back(model_ch(0));
    exp_q.push_back(model_ch(1));
    rd_addr = 1'b1;
    wait_ce(n);
    check({tag, ":ce0"}, 32'(ce), 32'd1);
    if (after_reset) check({tag, ":start"}, n, (2**DW) + (clr_tab[0] ? 2 : 7));
    obs0 = m_k_out;
    check({tag, ":m0"}, 32'(m_k_out), 32'(exp_q.pop_front()));
    wait_ce(n);
    check({tag, ":ce1"}, 32'(ce), 32'd1);
    check({tag, ":gap"}, n, clr_tab[1] ? 2 : 7);
    obs1 = m_k_out;
    check({tag, ":m1"}, 32'(m_k_out), 32'(exp_q.pop_front()));
    check({tag, ":rd_old"}, 32'(rd_data), 32'(old1));
    check({tag, ":a_wrap"}, 32'(a), 32'd0);
    @(negedge clk);
    check({tag, ":rd_new"}, 32'(rd_data), 32'(mm[1]));
    rd_addr = 1'b0;
    @(negedge clk);
    check({tag, ":rd0"}, 32'(rd_data), 32'(mm[0]));
    rd_addr = 1'b1;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic [11:0] o0, o1;
    int n;
    rd_addr = 1'b1;
    model_reset();
    set_ch(0, 100, 2, -20, -20, 1'b0);
    set_ch(1, -50, 2, -20, -20, 1'b0);
    reset = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_ce", 32'(ce), 32'd0);
    check("rst_m", 32'(m_k_out), 32'd0);
    check("rst_rd", 32'(rd_data), 32'd0);
    check("rst_a", 32'(a), 32'd0);
    reset = 1'b0;

    run_frame("f1", 1'b1, o0, o1);
    check("f1_p_only", 32'(o0), 32'd400);
    run_frame("f2", 1'b0, o0, o1);
    check("f2_p_only", 32'(o0), 32'd400);
    clr_tab[0] = 1'b1;
    run_frame("f3_clr", 1'b0, o0, o1);
    check("f3_clr_m0", 32'(o0), 32'd0);
    clr_tab[0] = 1'b0;
    run_frame("f4", 1'b0, o0, o1);
    check("f4_after_clr", 32'(o0), 32'd400);

    // Abort a frame while channel 1 is in flight.
    wait_ce(n);
    check("abort_ce0", 32'(ce), 32'd1);
    check("abort_m0", 32'(m_k_out), 32'(model_ch(0)));
    #2 reset = 1'b1;
    #1;
    check("abort_ce", 32'(ce), 32'd0);
    check("abort_m", 32'(m_k_out), 32'd0);
    check("abort_rd", 32'(rd_data), 32'd0);
    check("abort_a", 32'(a), 32'd0);
    model_reset();
    set_ch(0, 1000, 3, -20, -20, 1'b0);
    set_ch(1, -1000, 3, -20, -20, 1'b0);
    @(negedge clk);
    reset = 1'b0;
    run_frame("clamp", 1'b1, o0, o1);
    check("clamp_hi", 32'(o0), 32'h7F8);
    check("clamp_lo", 32'(o1), 32'h808);

    for (int f = 0; f < 8; f++) begin
      for (int c = 0; c < 2; c++) begin
        set_ch(c, int'($urandom_range(200000)) - 100000,
               int'($urandom_range(11)) - 5,
               int'($urandom_range(15)) - 5,
               int'($urandom_range(8)) - 20,
               $urandom_range(4) == 0);
      end
      run_frame("rnd", 1'b0, o0, o1);
    end

    // ---------------- final report ----------------
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
